// File: rtl/uart_4b5b_bridge.sv
// uart_4b5b_bridge: 8N1 receiver -> byte FIFO -> transmitter.
// MODE 0 sends each byte as two 4B/5B symbols in a 12-bit frame.
// MODE 1 forwards the raw byte as a 10-bit 8N1 frame.
// FRAME_ERR and OVERFLOW are sticky until CLR_ERR is pulsed.
module uart_4b5b_bridge #(
  parameter int RX_DIV  = 5208,
  parameter int TX_DIV  = 4340,
  parameter int FIFO_AW = 4,
  parameter int MODE    = 0
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic       RS232_DCE_RXD,
  input  logic       CLR_ERR,
  output logic       RS232_DTE_TXD,
  output logic [7:0] LED,
  output logic       FRAME_ERR,
  output logic       OVERFLOW,
  output logic       TX_BUSY
);

  localparam int MAX_DIV    = (RX_DIV > TX_DIV) ? RX_DIV : TX_DIV;
  localparam int CNT_W      = $clog2(MAX_DIV) + 1;
  localparam int DEPTH      = 1 << FIFO_AW;
  localparam int FRAME_BITS = (MODE == 0) ? 12 : 10;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RX_HALF_LAST = CNT_W'(RX_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] RX_LAST      = CNT_W'(RX_DIV - 1);
  localparam logic [CNT_W-1:0] TX_LAST      = CNT_W'(TX_DIV - 1);
  localparam logic [3:0]       TX_BIT_LAST  = 4'(FRAME_BITS - 1);

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

  localparam logic [0:0] TX_IDLE  = 1'b0;
  localparam logic [0:0] TX_SHIFT = 1'b1;

  // 4B/5B symbol for one nibble (symbol bit 0 goes on the wire first)
  function automatic logic [4:0] enc5(input logic [3:0] n);
    logic [4:0] s;
    case (n)
      4'h0: s = 5'b11110;  4'h1: s = 5'b01001;
      4'h2: s = 5'b10100;  4'h3: s = 5'b10101;
      4'h4: s = 5'b01010;  4'h5: s = 5'b01011;
      4'h6: s = 5'b01110;  4'h7: s = 5'b01111;
      4'h8: s = 5'b10010;  4'h9: s = 5'b10011;
      4'hA: s = 5'b10110;  4'hB: s = 5'b10111;
      4'hC: s = 5'b11010;  4'hD: s = 5'b11011;
      4'hE: s = 5'b11100;  default: s = 5'b11101;
    endcase
    return s;
  endfunction

  // Shift-register image of a frame, bit 0 first; unused upper bits idle high
  function automatic logic [11:0] frame_load(input logic [7:0] b);
    if (MODE == 0) return {1'b1, enc5(b[7:4]), enc5(b[3:0]), 1'b0};
    else           return {3'b111, b, 1'b0};
  endfunction

  logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [2:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sr_q, rx_sr_d;
  logic             rx_push, rx_ferr_set;

  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       fifo_rdata;
  logic             fifo_full, fifo_empty, push_ok, ovf_set;

  logic [0:0]       tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [11:0]      tx_sr_q, tx_sr_d;
  logic             tx_pop;

  logic [7:0]       led_q, led_d;
  logic             ferr_q, ferr_d, ovf_q, ovf_d;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= RS232_DCE_RXD;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // RX FSM: mid-bit sampling; a start bit that reads high again is a glitch
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sr_d     = rx_sr_q;
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == RX_HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == RX_LAST) begin
          rx_cnt_d = '0;
          rx_sr_d  = {rxd_sync_q, rx_sr_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == RX_LAST) begin
          rx_cnt_d = '0;
          if (rxd_sync_q) begin
            rx_push    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_set = 1'b1;
            rx_state_d  = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_WAIT_HIGH: begin
        if (rxd_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // FIFO status; a push into a full FIFO survives only if a pop frees a slot
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    fifo_rdata = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    push_ok    = rx_push && (!fifo_full || tx_pop);
    ovf_set    = rx_push && fifo_full && !tx_pop;
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = tx_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // TX FSM: each bit held TX_DIV cycles; reload at stop-bit end if more data waits
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sr_d    = tx_sr_q;
    tx_pop     = 1'b0;
    if (tx_state_q == TX_IDLE) begin
      if (!fifo_empty) begin
        tx_pop     = 1'b1;
        tx_sr_d    = frame_load(fifo_rdata);
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_SHIFT;
      end
    end else if (tx_cnt_q == TX_LAST) begin
      tx_cnt_d = '0;
      if (tx_bit_q == TX_BIT_LAST) begin
        tx_bit_d = '0;
        if (!fifo_empty) begin
          tx_pop  = 1'b1;
          tx_sr_d = frame_load(fifo_rdata);
        end else begin
          tx_sr_d    = '1;
          tx_state_d = TX_IDLE;
        end
      end else begin
        tx_sr_d  = {1'b1, tx_sr_q[11:1]};
        tx_bit_d = tx_bit_q + 4'd1;
      end
    end else begin
      tx_cnt_d = tx_cnt_q + CNT_ONE;
    end
  end

  // LED and sticky flags; CLR_ERR wins over a same-cycle set
  always_comb begin
    led_d  = push_ok ? rx_sr_q : led_q;
    ferr_d = CLR_ERR ? 1'b0 : (rx_ferr_set ? 1'b1 : ferr_q);
    ovf_d  = CLR_ERR ? 1'b0 : (ovf_set ? 1'b1 : ovf_q);
  end

  // Control and output state
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sr_q    <= '1;
      led_q      <= '0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sr_q    <= tx_sr_d;
      led_q      <= led_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
    end
  end

  // Datapath storage: RX shift register and FIFO memory need no reset
  always_ff @(posedge CLK_50M) begin
    rx_sr_q <= rx_sr_d;
    if (push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= rx_sr_q;
  end

  assign RS232_DTE_TXD = tx_sr_q[0];
  assign TX_BUSY       = (tx_state_q == TX_SHIFT);
  assign LED           = led_q;
  assign FRAME_ERR     = ferr_q;
  assign OVERFLOW      = ovf_q;

endmodule
